// File: rtl/sha3_msg_sequencer_if.sv
// Signal bundle between the message sequencer, its byte source, the sha3 core
// and the digest consumer. master = sequencer side, slave = environment side.
interface sha3_msg_sequencer_if;
   logic [7:0]   s_data;
   logic         s_valid;
   logic         s_last;
   logic         s_ready;
   logic [63:0]  core_in;
   logic         core_in_ready;
   logic         core_is_last;
   logic [2:0]   core_byte_num;
   logic         core_buffer_full;
   logic [511:0] core_out;
   logic         core_out_ready;
   logic         core_reset;
   logic [511:0] digest;
   logic         digest_valid;
   logic         digest_ack;
   logic         busy;
   logic         err;

   modport master (
      input  s_data, s_valid, s_last, core_buffer_full, core_out, core_out_ready, digest_ack,
      output s_ready, core_in, core_in_ready, core_is_last, core_byte_num, core_reset,
             digest, digest_valid, busy, err
   );

   modport slave (
      output s_data, s_valid, s_last, core_buffer_full, core_out, core_out_ready, digest_ack,
      input  s_ready, core_in, core_in_ready, core_is_last, core_byte_num, core_reset,
             digest, digest_valid, busy, err
   );
endinterface

// File: rtl/sha3_msg_sequencer.sv
// Packs a byte stream into 64-bit words for the sha3 core, terminates the message,
// captures the digest until acknowledged and then resets the core.
module sha3_msg_sequencer #(
   parameter int TIMEOUT = 4096,
   parameter int TO_W    = 12
) (
   input  logic clk,
   input  logic reset,
   sha3_msg_sequencer_if.master bus
);

   typedef enum logic [2:0] {
      IDLE, COLLECT, ISSUE, ISSUE_PAD, WAIT_DIGEST, HOLD, CORE_RST
   } state_t;

   localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

   state_t          state_q;
   logic [3:0]      cnt_q;
   logic            last_q;
   logic            issue_q;
   logic [TO_W-1:0] to_cnt_q;
   logic            s_ready_q;
   logic            is_last_q;
   logic [2:0]      byte_num_q;
   logic            core_reset_q;
   logic [511:0]    digest_q;
   logic            digest_valid_q;
   logic            busy_q;
   logic            err_q;

   logic            accept;
   logic            strobe;
   logic [3:0]      cnt_inc;
   logic [2:0]      wr_idx;
   logic            lane_clr;
   logic [63:0]     word;

   assign accept   = bus.s_valid & s_ready_q;
   // issue_q arms the strobe; the core's back-pressure gates it in the same cycle
   assign strobe   = issue_q & ~bus.core_buffer_full;
   assign cnt_inc  = cnt_q + 4'd1;
   assign wr_idx   = (state_q == IDLE) ? 3'd0 : cnt_q[2:0];
   assign lane_clr = (state_q == IDLE) || ((state_q == ISSUE) && strobe);

   for (genvar gi = 0; gi < 8; gi++) begin : g_lane
      logic [7:0] lane_q;
      always_ff @(posedge clk) begin
         if (reset) begin
            lane_q <= '0;
         end else if (accept && (wr_idx == 3'(gi))) begin
            lane_q <= bus.s_data;
         end else if (lane_clr) begin
            lane_q <= '0;
         end
      end
      assign word[63-8*gi -: 8] = lane_q;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q        <= IDLE;
         cnt_q          <= '0;
         last_q         <= 1'b0;
         issue_q        <= 1'b0;
         to_cnt_q       <= '0;
         s_ready_q      <= 1'b0;
         is_last_q      <= 1'b0;
         byte_num_q     <= '0;
         core_reset_q   <= 1'b1;
         digest_q       <= '0;
         digest_valid_q <= 1'b0;
         busy_q         <= 1'b0;
         err_q          <= 1'b0;
      end else begin
         core_reset_q <= 1'b0;
         case (state_q)
            IDLE: begin
               s_ready_q <= 1'b1;
               if (accept) begin
                  cnt_q  <= 4'd1;
                  last_q <= bus.s_last;
                  err_q  <= 1'b0;
                  busy_q <= 1'b1;
                  if (bus.s_last) begin
                     state_q    <= ISSUE;
                     s_ready_q  <= 1'b0;
                     issue_q    <= 1'b1;
                     is_last_q  <= 1'b1;
                     byte_num_q <= 3'd1;
                  end else begin
                     state_q <= COLLECT;
                  end
               end
            end
            COLLECT: begin
               if (accept) begin
                  cnt_q  <= cnt_inc;
                  last_q <= bus.s_last;
                  if (bus.s_last || (cnt_inc == 4'd8)) begin
                     state_q    <= ISSUE;
                     s_ready_q  <= 1'b0;
                     issue_q    <= 1'b1;
                     // a full last word goes out as a normal word; the pad word terminates
                     is_last_q  <= bus.s_last && (cnt_inc != 4'd8);
                     byte_num_q <= cnt_inc[2:0];
                  end
               end
            end
            ISSUE: begin
               if (strobe) begin
                  issue_q    <= 1'b0;
                  is_last_q  <= 1'b0;
                  byte_num_q <= '0;
                  if (!last_q) begin
                     state_q   <= COLLECT;
                     cnt_q     <= '0;
                     s_ready_q <= 1'b1;
                  end else if (cnt_q == 4'd8) begin
                     state_q <= ISSUE_PAD;
                  end else begin
                     state_q  <= WAIT_DIGEST;
                     to_cnt_q <= '0;
                  end
               end
            end
            ISSUE_PAD: begin
               // first cycle here is a gap so two strobes are never adjacent
               if (!issue_q) begin
                  issue_q    <= 1'b1;
                  is_last_q  <= 1'b1;
                  byte_num_q <= '0;
               end else if (strobe) begin
                  issue_q   <= 1'b0;
                  is_last_q <= 1'b0;
                  state_q   <= WAIT_DIGEST;
                  to_cnt_q  <= '0;
               end
            end
            WAIT_DIGEST: begin
               if (bus.core_out_ready) begin
                  digest_q       <= bus.core_out;
                  digest_valid_q <= 1'b1;
                  state_q        <= HOLD;
               end else if (to_cnt_q == TO_LAST) begin
                  err_q        <= 1'b1;
                  state_q      <= CORE_RST;
                  core_reset_q <= 1'b1;
               end else begin
                  to_cnt_q <= to_cnt_q + TO_W'(1);
               end
            end
            HOLD: begin
               if (bus.digest_ack) begin
                  digest_valid_q <= 1'b0;
                  state_q        <= CORE_RST;
                  core_reset_q   <= 1'b1;
               end
            end
            CORE_RST: begin
               state_q   <= IDLE;
               s_ready_q <= 1'b1;
               busy_q    <= 1'b0;
               cnt_q     <= '0;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign bus.s_ready       = s_ready_q;
   assign bus.core_in       = word;
   assign bus.core_in_ready = strobe;
   assign bus.core_is_last  = is_last_q;
   assign bus.core_byte_num = byte_num_q;
   assign bus.core_reset    = core_reset_q;
   assign bus.digest        = digest_q;
   assign bus.digest_valid  = digest_valid_q;
   assign bus.busy          = busy_q;
   assign bus.err           = err_q;

endmodule

// File: tb/tb_sha3_msg_sequencer.sv
// Directed and randomized messages against a word-level model of the packing,
// termination and digest handshake of sha3_msg_sequencer.
module tb_sha3_msg_sequencer;
   localparam int TIMEOUT = 16;

   typedef struct packed {
      logic [63:0] data;
      logic        last;
      logic [2:0]  bn;
   } word_t;

   logic clk = 1'b0;
   logic reset = 1'b1;

   sha3_msg_sequencer_if bus();

   sha3_msg_sequencer #(.TIMEOUT(TIMEOUT), .TO_W(12)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int           checks = 0;
   int           failures = 0;
   int           cyc = 0;
   int           last_strobe_cyc = -1;
   int           bf_mode = 0;
   bit           core_en = 1'b1;
   int           cd = -1;
   bit           prev_strobe = 1'b0;
   logic [511:0] pattern = '0;
   word_t        obs_q[$];
   word_t        exp_q[$];

   task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Expected core words straight from the message: 8-byte chunks, MSB-first lanes,
   // a short tail is the last word, an exact multiple of 8 gets an empty last word.
   function automatic void model_words(input logic [7:0] msg[$]);
      int n;
      n = msg.size();
      exp_q.delete();
      for (int base = 0; base < n; base += 8) begin
         word_t w;
         int    rem;
         rem = n - base;
         w.data = '0;
         for (int j = 0; j < 8 && j < rem; j++) w.data[63-8*j -: 8] = msg[base+j];
         w.last = (rem < 8);
         w.bn   = (rem < 8) ? 3'(rem) : 3'd0;
         exp_q.push_back(w);
      end
      if (n % 8 == 0) begin
         word_t p;
         p.data = '0;
         p.last = 1'b1;
         p.bn   = 3'd0;
         exp_q.push_back(p);
      end
   endfunction

   // Environment: core back-pressure, model core digest return, strobe monitor.
   initial begin
      bus.core_buffer_full = 1'b0;
      bus.core_out_ready   = 1'b0;
      bus.core_out         = '0;
      forever begin
         @(posedge clk);
         cyc++;
         #3;
         case (bf_mode)
            0:       bus.core_buffer_full = 1'b0;
            1:       bus.core_buffer_full = ($urandom_range(0, 2) == 0);
            default: bus.core_buffer_full = 1'b1;
         endcase
         bus.core_out_ready = 1'b0;
         if (cd == 0) begin
            bus.core_out_ready = core_en;
            cd = -1;
         end else if (cd > 0) begin
            cd--;
         end
         bus.core_out = pattern;
         #1;
         if (bus.core_in_ready) begin
            word_t w;
            check("strobe_while_full", bus.core_buffer_full, 1'b0);
            check("strobe_back_to_back", prev_strobe, 1'b0);
            w.data = bus.core_in;
            w.last = bus.core_is_last;
            w.bn   = bus.core_byte_num;
            obs_q.push_back(w);
            if (bus.core_is_last) begin
               last_strobe_cyc = cyc;
               cd = 9;
            end
         end
         prev_strobe = bus.core_in_ready;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic apply_reset();
      reset = 1'b1;
      bus.s_valid = 1'b0;
      bus.s_last = 1'b0;
      bus.digest_ack = 1'b0;
      bf_mode = 0;
      cd = -1;
      repeat (2) tick();
      check("rst_s_ready", bus.s_ready, 1'b0);
      check("rst_core_in_ready", bus.core_in_ready, 1'b0);
      check("rst_core_is_last", bus.core_is_last, 1'b0);
      check("rst_core_byte_num", bus.core_byte_num, 3'd0);
      check("rst_core_in", bus.core_in, 64'd0);
      check("rst_core_reset", bus.core_reset, 1'b1);
      check("rst_digest", bus.digest, 512'd0);
      check("rst_digest_valid", bus.digest_valid, 1'b0);
      check("rst_err", bus.err, 1'b0);
      check("rst_busy", bus.busy, 1'b0);
      reset = 1'b0;
      tick();
      check("post_rst_core_reset", bus.core_reset, 1'b0);
      check("post_rst_s_ready", bus.s_ready, 1'b1);
      obs_q.delete();
   endtask

   task automatic send_bytes(input logic [7:0] msg[$], input int lo, input int hi,
                             input bit mark_last, input bit gaps);
      for (int i = lo; i < hi; i++) begin
         int t;
         if (gaps) repeat ($urandom_range(0, 2)) tick();
         bus.s_valid = 1'b1;
         bus.s_data  = msg[i];
         bus.s_last  = mark_last && (i == hi - 1);
         t = 0;
         while (!bus.s_ready && t < 200) begin
            tick();
            t++;
         end
         check("s_ready_wait", bus.s_ready, 1'b1);
         tick();
         bus.s_valid = 1'b0;
         bus.s_last  = 1'b0;
      end
   endtask

   task automatic finish_msg(input string tag);
      int t;
      t = 0;
      while (!bus.digest_valid && t < 300) begin
         tick();
         t++;
      end
      check({tag, "_digest_valid"}, bus.digest_valid, 1'b1);
      if (!bus.digest_valid) begin
         apply_reset();
         return;
      end
      check({tag, "_digest"}, bus.digest, pattern);
      check({tag, "_err"}, bus.err, 1'b0);
      check({tag, "_busy"}, bus.busy, 1'b1);
      check({tag, "_word_count"}, obs_q.size(), exp_q.size());
      for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
         check({tag, "_word_data"}, obs_q[i].data, exp_q[i].data);
         check({tag, "_word_last"}, obs_q[i].last, exp_q[i].last);
         check({tag, "_word_bn"}, obs_q[i].bn, exp_q[i].bn);
      end
      repeat ($urandom_range(1, 4)) begin
         tick();
         check({tag, "_hold_valid"}, bus.digest_valid, 1'b1);
         check({tag, "_hold_digest"}, bus.digest, pattern);
      end
      bus.digest_ack = 1'b1;
      tick();
      bus.digest_ack = 1'b0;
      check({tag, "_ack_valid"}, bus.digest_valid, 1'b0);
      check({tag, "_ack_core_reset"}, bus.core_reset, 1'b1);
      tick();
      check({tag, "_idle_core_reset"}, bus.core_reset, 1'b0);
      check({tag, "_idle_busy"}, bus.busy, 1'b0);
      check({tag, "_idle_s_ready"}, bus.s_ready, 1'b1);
      $display("msg %s len_words=%0d digest_ok=%0d", tag, obs_q.size(), bus.digest === pattern);
   endtask

   task automatic new_msg(input logic [7:0] msg[$]);
      for (int i = 0; i < 16; i++) pattern[32*i +: 32] = $urandom();
      model_words(msg);
      obs_q.delete();
      last_strobe_cyc = -1;
   endtask

   task automatic run_msg(input logic [7:0] msg[$], input bit gaps, input string tag);
      new_msg(msg);
      send_bytes(msg, 0, msg.size(), 1'b1, gaps);
      finish_msg(tag);
   endtask

   initial begin
      logic [7:0] msg[$];
      int         base;

      bus.s_valid = 1'b0;
      bus.s_last = 1'b0;
      bus.s_data = '0;
      bus.digest_ack = 1'b0;
      apply_reset();

      msg = '{8'h61, 8'h62, 8'h63};
      run_msg(msg, 1'b0, "abc");
      check("abc_lit_data", obs_q[0].data, 64'h6162630000000000);
      check("abc_lit_bn", obs_q[0].bn, 3'd3);

      msg = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
      run_msg(msg, 1'b0, "eight");
      check("eight_lit_w0", obs_q[0].data, 64'h0102030405060708);
      check("eight_lit_w0_last", obs_q[0].last, 1'b0);
      check("eight_lit_pad_last", obs_q[1].last, 1'b1);

      msg.delete();
      for (int i = 0; i < 11; i++) msg.push_back(8'(8'h20 + i));
      new_msg(msg);
      bf_mode = 2;
      send_bytes(msg, 0, 8, 1'b0, 1'b0);
      repeat (5) begin
         tick();
         check("full_s_ready", bus.s_ready, 1'b0);
         check("full_no_strobe", obs_q.size(), 0);
      end
      bf_mode = 0;
      send_bytes(msg, 8, 11, 1'b1, 1'b0);
      finish_msg("full11");

      for (int r = 0; r < 6; r++) begin
         int len;
         len = $urandom_range(1, 20);
         msg.delete();
         for (int i = 0; i < len; i++) msg.push_back(8'($urandom()));
         bf_mode = 1;
         run_msg(msg, 1'b1, "rand");
         bf_mode = 0;
      end

      core_en = 1'b0;
      msg = '{8'hA5};
      new_msg(msg);
      send_bytes(msg, 0, 1, 1'b1, 1'b0);
      base = 0;
      while (last_strobe_cyc < 0 && base < 50) begin
         tick();
         base++;
      end
      check("to_strobe_seen", last_strobe_cyc >= 0, 1'b1);
      check("to_word_count", obs_q.size(), exp_q.size());
      base = last_strobe_cyc;
      while (cyc < base + 16) tick();
      check("to_err_before", bus.err, 1'b0);
      check("to_busy_before", bus.busy, 1'b1);
      tick();
      check("to_err_set", bus.err, 1'b1);
      check("to_core_reset", bus.core_reset, 1'b1);
      check("to_digest_valid", bus.digest_valid, 1'b0);
      tick();
      check("to_idle_busy", bus.busy, 1'b0);
      check("to_idle_core_reset", bus.core_reset, 1'b0);
      check("to_err_sticky", bus.err, 1'b1);
      check("to_idle_s_ready", bus.s_ready, 1'b1);
      core_en = 1'b1;
      $display("msg timeout err=%0d", bus.err);

      msg = '{8'h11, 8'h22};
      new_msg(msg);
      send_bytes(msg, 0, 1, 1'b0, 1'b0);
      check("err_cleared", bus.err, 1'b0);
      send_bytes(msg, 1, 2, 1'b1, 1'b0);
      finish_msg("after_to");

      msg = '{8'hF1, 8'hF2, 8'hF3, 8'hF4, 8'hF5};
      new_msg(msg);
      send_bytes(msg, 0, 5, 1'b0, 1'b0);
      check("mid_busy", bus.busy, 1'b1);
      apply_reset();
      msg = '{8'h9A, 8'hBC, 8'hDE};
      run_msg(msg, 1'b0, "post_rst");
      check("post_rst_lane0", obs_q[0].data, 64'h9ABCDE0000000000);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, checks=%0d failures=%0d", checks, failures);
      $fatal(1, "watchdog expired");
   end
endmodule
